// File: rtl/bb_iic.sv
// Bit-banged I2C master for an MPU-class sensor: a five-write configuration sequence
// and a 14-byte burst read, both driven from a small sequence ROM.
`timescale 1ns/1ps
module bb_iic #(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         IIC_HZ   = 400_000,
    parameter logic [6:0] DEV_ADDR = 7'h68
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mpu_init,
    input  logic       mpu_transfer,
    output logic       scl,
    inout  wire        sda,
    output logic       data_avalid,
    output logic [7:0] data,
    output logic       busy_now
);
    localparam int Q  = CLK_HZ / (4 * IIC_HZ);
    localparam int QW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [3:0] {
        IDLE, START, RESTART, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, GAP
    } state_t;

    state_t          state, next_state;
    logic [QW-1:0]   qcnt;
    logic [1:0]      quarter;
    logic [2:0]      bitcnt;
    logic [3:0]      idx;
    logic [2:0]      txn;
    logic            mode;
    logic [7:0]      tx_sh;
    logic [6:0]      rx_sh;
    logic            sda_low;
    logic            sda_in;
    logic            qtick;
    logic            step_done;
    logic [1:0]      last_q;

    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    // START and STOP are three-quarter sequences; every other state spans a full slot.
    assign last_q    = (state == START || state == STOP) ? 2'd2 : 2'd3;
    assign qtick     = (qcnt == QW'(Q - 1));
    assign step_done = qtick && (quarter == last_q);

    function automatic logic [7:0] rom_byte(input logic xfer, input logic [2:0] t,
                                            input logic [3:0] i);
        logic [15:0] pair;
        case (t)
            3'd0:    pair = 16'h6B00;
            3'd1:    pair = 16'h1907;
            3'd2:    pair = 16'h1A06;
            3'd3:    pair = 16'h1B18;
            default: pair = 16'h1C01;
        endcase
        if (i == 4'd0)
            rom_byte = {DEV_ADDR, 1'b0};
        else if (xfer)
            rom_byte = (i == 4'd1) ? 8'h3B : {DEV_ADDR, 1'b1};
        else
            rom_byte = (i == 4'd1) ? pair[15:8] : pair[7:0];
    endfunction

    function automatic state_t rom_next(input logic xfer, input logic [3:0] i);
        if (xfer && i == 4'd1)
            rom_next = RESTART;
        else if (i < 4'd2)
            rom_next = WR_BYTE;
        else if (xfer)
            rom_next = RD_BYTE;
        else
            rom_next = STOP;
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:          if (mpu_init || mpu_transfer) next_state = START;
            START,
            RESTART:       if (step_done) next_state = WR_BYTE;
            WR_BYTE:       if (step_done && bitcnt == 3'd7) next_state = WR_ACK;
            WR_ACK:        if (step_done) next_state = rom_next(mode, idx);
            RD_BYTE:       if (step_done && bitcnt == 3'd7) next_state = RD_ACK;
            RD_ACK:        if (step_done) next_state = (idx == 4'd13) ? STOP : RD_BYTE;
            STOP:          if (step_done) next_state = (!mode && txn != 3'd4) ? GAP : IDLE;
            GAP:           if (step_done) next_state = START;
            default:       next_state = IDLE;
        endcase
    end

    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state)
            START:   begin scl = (quarter != 2'd2); sda_low = (quarter != 2'd0); end
            RESTART: begin scl = (quarter == 2'd1 || quarter == 2'd2); sda_low = quarter[1]; end
            WR_BYTE: begin scl = (quarter == 2'd1 || quarter == 2'd2); sda_low = !tx_sh[7]; end
            WR_ACK,
            RD_BYTE: scl = (quarter == 2'd1 || quarter == 2'd2);
            RD_ACK:  begin scl = (quarter == 2'd1 || quarter == 2'd2); sda_low = (idx != 4'd13); end
            STOP:    begin scl = (quarter != 2'd0); sda_low = (quarter != 2'd2); end
            default: ;
        endcase
    end

    assign busy_now = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            qcnt        <= '0;
            quarter     <= '0;
            bitcnt      <= '0;
            idx         <= '0;
            txn         <= '0;
            mode        <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            data        <= 8'h00;
            data_avalid <= 1'b0;
        end else begin
            data_avalid <= 1'b0;
            if (state == IDLE) begin
                qcnt    <= '0;
                quarter <= '0;
                bitcnt  <= '0;
                idx     <= '0;
                txn     <= '0;
                mode    <= !mpu_init;
                tx_sh   <= {DEV_ADDR, 1'b0};
            end else begin
                qcnt <= qtick ? '0 : qcnt + 1'b1;
                if (qtick)
                    quarter <= step_done ? 2'd0 : quarter + 2'd1;
                // Sample once, on the first cycle of the SCL-high second quarter.
                if (state == RD_BYTE && quarter == 2'd2 && qcnt == '0) begin
                    rx_sh <= {rx_sh[5:0], sda_in};
                    if (bitcnt == 3'd7) begin
                        data        <= {rx_sh, sda_in};
                        data_avalid <= 1'b1;
                    end
                end
                if (step_done) begin
                    case (state)
                        WR_BYTE: begin
                            bitcnt <= bitcnt + 3'd1;
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                        end
                        RD_BYTE: bitcnt <= bitcnt + 3'd1;
                        WR_ACK: begin
                            idx   <= (mode && idx == 4'd2) ? 4'd0 : idx + 4'd1;
                            tx_sh <= rom_byte(mode, txn, idx + 4'd1);
                        end
                        RD_ACK: idx <= idx + 4'd1;
                        STOP: begin
                            idx   <= '0;
                            tx_sh <= {DEV_ADDR, 1'b0};
                        end
                        GAP:     txn <= txn + 3'd1;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_bb_iic.sv
// Bench for bb_iic: an I2C slave model decodes the bus into tokens and returns 01..0E on
// reads; bus tokens and read bytes are scored against queues filled when stimulus is driven.
`timescale 1ns/1ps
module tb_bb_iic;
    localparam int CLK_HZ   = 6_400_000;
    localparam int IIC_HZ   = 400_000;
    localparam int Q        = CLK_HZ / (4 * IIC_HZ);
    localparam int INIT_CYC = 586 * Q;
    localparam int XFER_CYC = 622 * Q;
    localparam int T_START  = 256;
    localparam int T_STOP   = 512;
    localparam int T_ACK    = 768;
    localparam int T_NACK   = 769;

    logic       clk = 1'b0;
    logic       rst_n, mpu_init, mpu_transfer;
    logic       scl, data_avalid, busy_now;
    logic [7:0] data;
    wire        sda;
    logic       slv_low = 1'b0;
    logic       slv_off = 1'b0;

    assign sda = (slv_low && !slv_off) ? 1'b0 : 1'bz;
    pullup (sda);

    bb_iic #(.CLK_HZ(CLK_HZ), .IIC_HZ(IIC_HZ), .DEV_ADDR(7'h68)) dut (
        .clk(clk), .rst_n(rst_n), .mpu_init(mpu_init), .mpu_transfer(mpu_transfer),
        .scl(scl), .sda(sda), .data_avalid(data_avalid), .data(data), .busy_now(busy_now)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_tok[$];
    int exp_dat[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tok(input int t);
        if (exp_tok.size() == 0) check("tok_extra", t, -1);
        else check("bus_token", t, exp_tok.pop_front());
    endtask

    task automatic push_init();
        int regs [5] = '{'h6B, 'h19, 'h1A, 'h1B, 'h1C};
        int vals [5] = '{'h00, 'h07, 'h06, 'h18, 'h01};
        for (int i = 0; i < 5; i++) begin
            exp_tok.push_back(T_START);
            exp_tok.push_back('hD0);
            exp_tok.push_back(regs[i]);
            exp_tok.push_back(vals[i]);
            exp_tok.push_back(T_STOP);
        end
    endtask

    task automatic push_xfer();
        exp_tok.push_back(T_START);
        exp_tok.push_back('hD0);
        exp_tok.push_back('h3B);
        exp_tok.push_back(T_START);
        exp_tok.push_back('hD1);
        for (int i = 1; i <= 14; i++) begin
            exp_dat.push_back(i);
            exp_tok.push_back(i == 14 ? T_NACK : T_ACK);
        end
        exp_tok.push_back(T_STOP);
    endtask

    // Slave model and output monitor, both sampled on the falling system clock.
    int         bitn = 0;
    logic       rd = 1'b0, rd_next = 1'b0, nack = 1'b0, addr = 1'b0;
    logic [7:0] sh = '0, tx = '0;
    logic       p_scl = 1'b1, p_sda = 1'b1, p_av = 1'b0, p_busy = 1'b0;
    logic       mon_en = 1'b0;
    int         n_av = 0, runs = 0, busy_cyc = 0, idle_run = 0;

    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda;
        if (!mon_en) begin
            bitn = 0; rd = 1'b0; rd_next = 1'b0; nack = 1'b0; addr = 1'b0; slv_low = 1'b0;
        end else if (p_scl && s_scl && p_sda && !s_sda) begin
            tok(T_START);
            bitn = 0; rd = 1'b0; rd_next = 1'b0; nack = 1'b0; addr = 1'b1; slv_low = 1'b0;
        end else if (p_scl && s_scl && !p_sda && s_sda) begin
            tok(T_STOP);
            slv_low = 1'b0;
        end else if (!p_scl && s_scl) begin
            if (bitn < 8) begin
                if (!rd) sh = {sh[6:0], s_sda};
            end else if (rd) begin
                nack = s_sda;
                tok(s_sda ? T_NACK : T_ACK);
                if (!s_sda) tx = tx + 8'd1;
            end
            bitn++;
        end else if (p_scl && !s_scl) begin
            if (bitn == 8) begin
                if (!rd) begin
                    tok(int'(sh));
                    rd_next = addr && sh[0];
                    addr    = 1'b0;
                    slv_low = 1'b1;
                end else begin
                    slv_low = 1'b0;
                end
            end else if (bitn == 9) begin
                bitn = 0;
                if (rd_next) begin rd = 1'b1; rd_next = 1'b0; tx = 8'd1; end
                slv_low = rd && !nack && !tx[7];
            end else if (rd && bitn >= 1) begin
                slv_low = !tx[3'(7 - bitn)];
            end else begin
                slv_low = 1'b0;
            end
        end
        if (mon_en && data_avalid) begin
            check("avalid_width", int'(p_av), 0);
            if (exp_dat.size() == 0) check("data_extra", int'(data), -1);
            else check("read_data", int'(data), exp_dat.pop_front());
            n_av++;
        end
        if (busy_now && !p_busy) begin
            if (runs > 0) check("busy_gap", idle_run, 1);
            runs++;
            idle_run = 0;
        end
        if (busy_now) busy_cyc++;
        else idle_run++;
        p_scl  = s_scl;
        p_sda  = s_sda;
        p_av   = data_avalid;
        p_busy = busy_now;
    end

    task automatic wait_idle();
        int cnt = 0;
        while (busy_now && cnt < 4 * XFER_CYC) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("idle_timeout", int'(busy_now), 0);
    endtask

    task automatic wait_runs(input int n);
        int cnt = 0;
        while (runs < n && cnt < 4 * XFER_CYC) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("runs_timeout", runs, n);
    endtask

    task automatic clear_counts();
        runs = 0; busy_cyc = 0; idle_run = 0; n_av = 0;
    endtask

    task automatic pulse_xfer();
        @(negedge clk); mpu_transfer = 1'b1;
        @(posedge clk); #1 mpu_transfer = 1'b0;
    endtask

    typedef struct {
        logic init;
        logic xfer;
        int   runs;
        int   busy;
        int   pulses;
    } vec_t;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [3];
        int   cnt;
        vecs[0] = '{init: 1'b1, xfer: 1'b0, runs: 1, busy: INIT_CYC,            pulses: 0};
        vecs[1] = '{init: 1'b0, xfer: 1'b1, runs: 2, busy: 2 * XFER_CYC,        pulses: 28};
        vecs[2] = '{init: 1'b1, xfer: 1'b1, runs: 2, busy: INIT_CYC + XFER_CYC, pulses: 14};

        rst_n = 1'b1; mpu_init = 1'b0; mpu_transfer = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_scl", int'(scl), 1);
        check("rst_sda", int'(sda), 1);
        check("rst_busy", int'(busy_now), 0);
        check("rst_data", int'(data), 0);
        check("rst_avalid", int'(data_avalid), 0);
        rst_n  = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int v = 0; v < 3; v++) begin
            clear_counts();
            if (vecs[v].init) push_init();
            if (vecs[v].xfer)
                for (int k = 0; k < vecs[v].runs - int'(vecs[v].init); k++) push_xfer();
            @(negedge clk);
            mpu_init     = vecs[v].init;
            mpu_transfer = vecs[v].xfer;
            @(posedge clk); #1;
            check("busy_rise", int'(busy_now), 1);
            mpu_init = 1'b0;
            wait_runs(vecs[v].runs);
            mpu_transfer = 1'b0;
            wait_idle();
            repeat (8 * Q) @(posedge clk);
            #1;
            check("vec_runs", runs, vecs[v].runs);
            check("vec_busy_cycles", busy_cyc, vecs[v].busy);
            check("vec_pulses", n_av, vecs[v].pulses);
            check("vec_tok_left", exp_tok.size(), 0);
            check("vec_dat_left", exp_dat.size(), 0);
        end

        // An init request during a busy transfer is dropped, not queued.
        clear_counts();
        push_xfer();
        pulse_xfer();
        repeat (100) @(posedge clk);
        #1 mpu_init = 1'b1;
        @(posedge clk); #1 mpu_init = 1'b0;
        wait_idle();
        repeat (40 * Q) @(posedge clk);
        #1;
        check("ign_runs", runs, 1);
        check("ign_busy_cycles", busy_cyc, XFER_CYC);
        check("ign_busy_now", int'(busy_now), 0);
        check("ign_tok_left", exp_tok.size(), 0);

        // Reset in the middle of a read byte, then a fresh transfer.
        clear_counts();
        push_xfer();
        pulse_xfer();
        cnt = 0;
        while (n_av < 3 && cnt < 2 * XFER_CYC) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("mid_avalid_count", n_av, 3);
        repeat (10 * Q) @(posedge clk);
        @(negedge clk);
        mon_en  = 1'b0;
        slv_off = 1'b1;
        rst_n   = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_scl", int'(scl), 1);
        check("mid_rst_sda", int'(sda), 1);
        check("mid_rst_busy", int'(busy_now), 0);
        check("mid_rst_data", int'(data), 0);
        check("mid_rst_avalid", int'(data_avalid), 0);
        rst_n = 1'b0;
        exp_tok.delete();
        exp_dat.delete();
        slv_off = 1'b0;
        repeat (4) @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk); #1;
        clear_counts();
        push_xfer();
        pulse_xfer();
        wait_idle();
        repeat (8 * Q) @(posedge clk);
        #1;
        check("post_rst_runs", runs, 1);
        check("post_rst_busy_cycles", busy_cyc, XFER_CYC);
        check("post_rst_pulses", n_av, 14);
        check("post_rst_tok_left", exp_tok.size(), 0);
        check("post_rst_data", int'(data), 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bb_iic.md
BB_IIC -- requirements
Module: bb_iic

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CLK_HZ, 50_000_000, system clock frequency.
- IIC_HZ, 400_000, SCL frequency.
- DEV_ADDR, 7'h68, 7-bit MPU slave address.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, input, 1, single system clock; all logic on its rising edge.
- rst_n, input, 1, synchronous active-high reset (port name kept for codebase compatibility; reset is asserted when high).
- mpu_init, input, 1, request for the MPU configuration write sequence.
- mpu_transfer, input, 1, request for the sensor burst read.
- scl, output, 1, I2C clock, push-pull.
- sda, inout, 1, I2C data, open-drain: drives 0 or releases to Z; never drives 1.
- data_avalid, output, 1, one-cycle strobe marking a valid read byte.
- data, output, 8, last received byte.
- busy_now, output, 1, high while any transaction is in progress.

Function
REQ-003 Bit timing SHALL use a quarter-period Q = CLK_HZ/(4*IIC_HZ) clocks (integer division; 31 at defaults); every bit slot SHALL be 4Q.
REQ-004 Each bit slot SHALL run in four quarters:
- Q0: SCL low, set SDA.
- Q1: SCL rises.
- Q2: sample SDA at the start of this quarter.
- Q3: SCL low.
REQ-005 START SHALL drive SDA released and SCL high, then SDA low, then SCL low, one Q per step.
REQ-006 Repeated START SHALL release SDA with SCL low, raise SCL, drive SDA low, then drive SCL low.
REQ-007 STOP SHALL drive SDA low with SCL low, raise SCL, then release SDA.
REQ-008 Bytes SHALL be shifted MSB first. After each written byte there SHALL be one ACK slot with SDA released.
REQ-009 The ACK bit SHALL be sampled but ignored; the transaction SHALL continue on NACK.
REQ-010 In IDLE, the FSM SHALL sample requests every cycle, both level-sensitive. If both are high, mpu_init SHALL win.
REQ-011 Requests arriving while busy_now=1 SHALL be ignored and not queued.
REQ-012 busy_now SHALL be set on the same clock edge that samples the request in IDLE.
REQ-013 busy_now SHALL clear on the edge where the final STOP completes and the FSM returns to IDLE.
REQ-014 The init sequence SHALL perform 5 separate transactions, each START, {DEV_ADDR,0}, reg, value, STOP, in this order:
- reg 6B, value 00.
- reg 19, value 07.
- reg 1A, value 06.
- reg 1B, value 18.
- reg 1C, value 01.
REQ-015 Between consecutive init transactions, busy_now SHALL stay high and the bus SHALL be idle for 4Q.
REQ-016 The transfer sequence SHALL be:
- START, {DEV_ADDR,0}, reg 3B.
- Repeated START, {DEV_ADDR,1}.
- Read 14 bytes; master drives ACK (SDA=0) after bytes 1-13 and NACK (SDA released) after byte 14.
- STOP.
REQ-017 After the 8th sample of each read byte, data SHALL load that byte and data_avalid SHALL pulse high for exactly 1 cycle.
REQ-018 data SHALL hold its value until the next read byte.
REQ-019 If mpu_transfer is still high when the module returns to IDLE, a new transfer SHALL start on the next cycle.
REQ-020 FSM states SHALL be IDLE, START, RESTART, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP, GAP.
REQ-021 A sequence ROM (init table, transfer descriptor) SHALL select the next byte and the next state.
REQ-022 data_avalid SHALL never assert during the init sequence.

Reset
REQ-023 While rst_n=1 at a clock edge, the next state SHALL be:
- FSM in IDLE, all counters 0.
- scl=1, sda=Z, data=8'h00, data_avalid=0, busy_now=0.
REQ-024 Reset SHALL override any in-progress transaction with no STOP generated. The bus SHALL show SCL high and SDA released one cycle after reset is sampled.

Verification
REQ-025 Assert reset for 2 cycles -> scl=1, sda=Z, busy_now=0, data=00, data_avalid=0.
REQ-026 Pulse mpu_init for 1 cycle, with the bench pulling SDA low in ACK slots -> busy_now rises on the sampling edge; SDA shows the 5 transactions D0 6B 00 ... D0 1C 01; busy_now falls after the 5th STOP; data_avalid never pulses.
REQ-027 Hold mpu_transfer high, with the bench slave returning 01..0E -> SDA shows D0 3B, repeated START, D1; exactly 14 one-cycle data_avalid pulses with data=01..0E in order; master NACK on byte 14, then STOP.
REQ-028 Assert mpu_init and mpu_transfer in the same cycle -> init sequence runs first; the transfer starts only after busy_now falls.
REQ-029 Pulse mpu_init while a transfer is busy -> ignored; no configuration write follows.
REQ-030 Assert rst_n mid-byte during a transfer -> on the next cycle scl=1, sda=Z, busy_now=0, data=00; a new request is then serviced normally.
